dmem_mmio_responder: RTL and testbench

//  Responder (memory side) of the hart data-memory port (addr/ren/wen/wdata/mask/rdata).

---
 rtl/dmem_mmio_responder_if.sv | 13 +
 rtl/dmem_mmio_responder.sv | 199 +++++++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_responder_if.sv
// Hart data-memory port: byte address, read/write strobes, write data with lane mask,
// and combinational read data returned by the memory side.
interface dmem_mmio_responder_if;
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;

    modport master (output addr, output ren, output wen, output wdata, output mask, input rdata);
    modport slave  (input addr, input ren, input wen, input wdata, input mask, output rdata);
endinterface

// File: rtl/dmem_mmio_responder.sv
// Memory-side responder for the hart data port: little-endian byte RAM plus an MMIO page
// holding an LED register, a free-running timer and an 8N1 UART transmitter.
module dmem_mmio_responder #(
    parameter int unsigned RAM_BYTES    = 1024,
    parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
    parameter int unsigned LED_W        = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    dmem_mmio_responder_if.slave  dmem,
    output logic [LED_W-1:0]      o_led,
    output logic                  o_uart_tx
);
    localparam int unsigned AW       = $clog2(RAM_BYTES);
    localparam int unsigned CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] OFF_LED    = 4'h0;
    localparam logic [3:0] OFF_TIMER  = 4'h4;
    localparam logic [3:0] OFF_UART   = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    logic [7:0]       mem [RAM_BYTES];
    logic [AW-1:0]    lane_idx_s [4];
    logic             ram_sel_s, mmio_sel_s, busy_s;
    logic             ram_we_s, led_wr_s, timer_wr_s, uart_wr_s, stat_wr_s;
    logic [3:0]       off_s;
    logic [31:0]      lane_bm_s, timer_inc_s, rdata_s;

    logic [LED_W-1:0] led_d, led_q;
    logic [31:0]      timer_d, timer_q;
    logic             overflow_d, overflow_q;

    uart_state_e      uart_state_q;
    logic [CW-1:0]    clk_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shreg_q;
    logic             tx_q;

    // Address decode, per-target write strobes and wrapped byte-lane indices
    always_comb begin
        ram_sel_s     = (dmem.addr < 32'(RAM_BYTES));
        mmio_sel_s    = (dmem.addr[31:4] == MMIO_BASE[31:4]);
        off_s         = dmem.addr[3:0];
        busy_s        = (uart_state_q != S_IDLE);
        ram_we_s      = dmem.wen & ram_sel_s;
        led_wr_s      = dmem.wen & mmio_sel_s & (off_s == OFF_LED);
        timer_wr_s    = dmem.wen & mmio_sel_s & (off_s == OFF_TIMER);
        uart_wr_s     = dmem.wen & mmio_sel_s & (off_s == OFF_UART) & dmem.mask[0];
        stat_wr_s     = dmem.wen & mmio_sel_s & (off_s == OFF_STATUS) & dmem.mask[0];
        lane_bm_s     = {{8{dmem.mask[3]}}, {8{dmem.mask[2]}}, {8{dmem.mask[1]}}, {8{dmem.mask[0]}}};
        timer_inc_s   = timer_q + 32'd1;
        lane_idx_s[0] = dmem.addr[AW-1:0];
        lane_idx_s[1] = dmem.addr[AW-1:0] + AW'(32'd1);
        lane_idx_s[2] = dmem.addr[AW-1:0] + AW'(32'd2);
        lane_idx_s[3] = dmem.addr[AW-1:0] + AW'(32'd3);
    end

    // Combinational read mux; anything unmapped or idle returns zero
    always_comb begin
        rdata_s = 32'h0;
        if (dmem.ren) begin
            if (ram_sel_s) begin
                rdata_s = {mem[lane_idx_s[3]], mem[lane_idx_s[2]], mem[lane_idx_s[1]], mem[lane_idx_s[0]]};
            end else if (mmio_sel_s) begin
                case (off_s)
                    OFF_LED:    rdata_s = 32'(led_q);
                    OFF_TIMER:  rdata_s = timer_q;
                    OFF_STATUS: rdata_s = {30'd0, overflow_q, busy_s};
                    default:    rdata_s = 32'h0;
                endcase
            end else begin
                rdata_s = 32'h0;
            end
        end else begin
            rdata_s = 32'h0;
        end
    end

    assign dmem.rdata = rdata_s;

    // Next-state for LED, timer and the sticky overflow flag
    always_comb begin
        led_d      = led_q;
        timer_d    = timer_inc_s;
        overflow_d = overflow_q;
        if (led_wr_s) begin
            led_d = (led_q & ~lane_bm_s[LED_W-1:0]) | (dmem.wdata[LED_W-1:0] & lane_bm_s[LED_W-1:0]);
        end else begin
            led_d = led_q;
        end
        // Unmasked timer lanes still advance, so a partial write never stalls the count
        if (timer_wr_s) begin
            timer_d = (timer_inc_s & ~lane_bm_s) | (dmem.wdata & lane_bm_s);
        end else begin
            timer_d = timer_inc_s;
        end
        if (uart_wr_s && busy_s) begin
            overflow_d = 1'b1;
        end else if (stat_wr_s && dmem.wdata[1]) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // RAM byte lanes; the array holds no reset value
    always_ff @(posedge i_clk) begin
        if (ram_we_s && dmem.mask[0]) mem[lane_idx_s[0]] <= dmem.wdata[7:0];
        if (ram_we_s && dmem.mask[1]) mem[lane_idx_s[1]] <= dmem.wdata[15:8];
        if (ram_we_s && dmem.mask[2]) mem[lane_idx_s[2]] <= dmem.wdata[23:16];
        if (ram_we_s && dmem.mask[3]) mem[lane_idx_s[3]] <= dmem.wdata[31:24];
    end

    // Register state for LED, timer and overflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            led_q      <= '0;
            timer_q    <= 32'h0;
            overflow_q <= 1'b0;
        end else begin
            led_q      <= led_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
        end
    end

    // UART transmitter FSM; tx_q is loaded with the level of the state being entered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            uart_state_q <= S_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 8'h00;
            tx_q         <= 1'b1;
        end else begin
            case (uart_state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (uart_wr_s) begin
                        uart_state_q <= S_START;
                        clk_cnt_q    <= '0;
                        shreg_q      <= dmem.wdata[7:0];
                        tx_q         <= 1'b0;
                    end
                end
                S_START: begin
                    if (clk_cnt_q == CNT_LAST) begin
                        uart_state_q <= S_DATA;
                        clk_cnt_q    <= '0;
                        bit_cnt_q    <= 3'd0;
                        tx_q         <= shreg_q[0];
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(32'd1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt_q == CNT_LAST) begin
                        clk_cnt_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            uart_state_q <= S_STOP;
                            tx_q         <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shreg_q   <= {1'b0, shreg_q[7:1]};
                            tx_q      <= shreg_q[1];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(32'd1);
                    end
                end
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (clk_cnt_q == CNT_LAST) begin
                        uart_state_q <= S_IDLE;
                        clk_cnt_q    <= '0;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(32'd1);
                    end
                end
                default: begin
                    uart_state_q <= S_IDLE;
                    clk_cnt_q    <= '0;
                    tx_q         <= 1'b1;
                end
            endcase
        end
    end

    assign o_led     = led_q;
    assign o_uart_tx = tx_q;
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench: table-driven bus vectors with a read-data scoreboard, plus
// hand-written sequences for the timer wrap, a UART frame and asynchronous reset.
module tb_dmem_mmio_responder;
    localparam logic [31:0] A_LED    = 32'h8000_0000;
    localparam logic [31:0] A_TIMER  = 32'h8000_0004;
    localparam logic [31:0] A_UART   = 32'h8000_0008;
    localparam logic [31:0] A_STATUS = 32'h8000_000C;

    typedef struct {
        logic [31:0] addr;
        logic        ren;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] led;
    logic       tx;
    int         total;
    int         passed;
    vec_t        vt[$];
    logic [31:0] sb_q[$];
    logic [9:0]  frame;

    dmem_mmio_responder_if bus ();

    dmem_mmio_responder #(
        .RAM_BYTES(1024), .MMIO_BASE(32'h8000_0000), .LED_W(8), .CLKS_PER_BIT(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .dmem(bus), .o_led(led), .o_uart_tx(tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic add(input logic [31:0] a, input logic r, input logic w,
                       input logic [31:0] d, input logic [3:0] m, input logic [31:0] e);
        vec_t v;
        v.addr = a; v.ren = r; v.wen = w; v.wdata = d; v.mask = m; v.exp = e;
        vt.push_back(v);
    endtask

    // One bus cycle: drive just after a rising edge, compare at the falling edge
    task automatic access(input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] d, input logic [3:0] m, input logic [31:0] e,
                          input string nm, input logic tx_chk, input logic tx_exp);
        logic [31:0] exp_v;
        bus.addr = a; bus.ren = r; bus.wen = w; bus.wdata = d; bus.mask = m;
        sb_q.push_back(e);
        @(negedge clk);
        exp_v = sb_q.pop_front();
        check(nm, bus.rdata, exp_v);
        if (tx_chk) check({nm, "_tx"}, {31'd0, tx}, {31'd0, tx_exp});
        @(posedge clk);
        #1;
        bus.ren = 1'b0; bus.wen = 1'b0; bus.mask = 4'h0; bus.wdata = 32'h0;
    endtask

    initial begin
        total = 0; passed = 0;
        frame = {1'b1, 8'h41, 1'b0};
        rst_n = 1'b0;
        bus.addr = A_STATUS; bus.ren = 1'b1; bus.wen = 1'b0; bus.wdata = 32'h0; bus.mask = 4'h0;

        @(negedge clk);
        check("rst_status", bus.rdata, 32'h0);
        check("rst_led", {24'd0, led}, 32'h0);
        check("rst_tx", {31'd0, tx}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1; bus.ren = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        access(A_TIMER, 1'b1, 1'b0, 32'h0, 4'h0, 32'd5, "timer_after_reset", 1'b0, 1'b1);

        add(32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0);
        add(32'h14, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0);
        add(32'h10, 1'b1, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF);
        add(32'h13, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0000_00DE);
        add(32'h10, 1'b0, 1'b1, 32'h0000_5500, 4'b0010, 32'h0);
        add(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 32'hDEAD_55EF);
        add(32'h20, 1'b0, 1'b1, 32'h1, 4'hF, 32'h0);
        add(32'h20, 1'b1, 1'b1, 32'h2, 4'hF, 32'h1);
        add(32'h20, 1'b1, 1'b0, 32'h0, 4'h0, 32'h2);
        add(32'h0, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0);
        add(32'h3FE, 1'b0, 1'b1, 32'h4433_2211, 4'hF, 32'h0);
        add(32'h3FE, 1'b1, 1'b0, 32'h0, 4'h0, 32'h4433_2211);
        add(32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0000_4433);
        add(A_LED, 1'b0, 1'b1, 32'hA5, 4'hF, 32'h0);
        add(A_LED, 1'b1, 1'b0, 32'h0, 4'h0, 32'hA5);
        add(A_LED, 1'b0, 1'b1, 32'h0000_3C00, 4'b0010, 32'h0);
        add(A_LED, 1'b1, 1'b0, 32'h0, 4'h0, 32'hA5);
        add(32'h4000_0000, 1'b0, 1'b1, 32'h1234_5678, 4'hF, 32'h0);
        add(32'h4000_0000, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        add(32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0000_4433);
        add(32'h400, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        add(32'h8000_0001, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        add(A_UART, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        add(A_STATUS, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        add(32'h10, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < vt.size(); i++) begin
            access(vt[i].addr, vt[i].ren, vt[i].wen, vt[i].wdata, vt[i].mask, vt[i].exp,
                   $sformatf("vec%0d", i), 1'b0, 1'b1);
        end
        check("led_pin", {24'd0, led}, 32'hA5);

        access(A_TIMER, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'hF, 32'h0, "tmr_wr", 1'b0, 1'b1);
        access(A_TIMER, 1'b1, 1'b0, 32'h0, 4'h0, 32'hFFFF_FFFE, "tmr_rd0", 1'b0, 1'b1);
        access(A_TIMER, 1'b1, 1'b0, 32'h0, 4'h0, 32'hFFFF_FFFF, "tmr_rd1", 1'b0, 1'b1);
        access(A_TIMER, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0000_0000, "tmr_wrap", 1'b0, 1'b1);
        access(A_TIMER, 1'b0, 1'b1, 32'h0000_AB00, 4'b0010, 32'h0, "tmr_mwr", 1'b0, 1'b1);
        access(A_TIMER, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0000_AB02, "tmr_mrd", 1'b0, 1'b1);

        access(A_UART, 1'b0, 1'b1, 32'h41, 4'h1, 32'h0, "uart_wr", 1'b1, 1'b1);
        for (int c = 0; c < 40; c++) begin
            string nm;
            nm = $sformatf("uart_c%0d", c);
            case (c)
                5:       access(A_UART, 1'b0, 1'b1, 32'h99, 4'h1, 32'h0, nm, 1'b1, frame[c/4]);
                6:       access(A_STATUS, 1'b1, 1'b0, 32'h0, 4'h0, 32'h3, nm, 1'b1, frame[c/4]);
                7:       access(A_STATUS, 1'b0, 1'b1, 32'h2, 4'h1, 32'h0, nm, 1'b1, frame[c/4]);
                8:       access(A_STATUS, 1'b1, 1'b0, 32'h0, 4'h0, 32'h1, nm, 1'b1, frame[c/4]);
                38:      access(A_STATUS, 1'b1, 1'b0, 32'h0, 4'h0, 32'h1, nm, 1'b1, frame[c/4]);
                39:      access(A_UART, 1'b0, 1'b1, 32'h00, 4'h1, 32'h0, nm, 1'b1, frame[c/4]);
                default: access(32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, nm, 1'b1, frame[c/4]);
            endcase
        end
        access(A_STATUS, 1'b1, 1'b0, 32'h0, 4'h0, 32'h2, "uart_end_status", 1'b1, 1'b1);
        access(A_STATUS, 1'b0, 1'b1, 32'h2, 4'h1, 32'h0, "ovf_clr", 1'b1, 1'b1);
        access(A_STATUS, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, "ovf_clr_rd", 1'b1, 1'b1);

        access(A_UART, 1'b0, 1'b1, 32'h41, 4'h1, 32'h0, "uart2_wr", 1'b1, 1'b1);
        access(32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, "uart2_c0", 1'b1, 1'b0);
        bus.addr = A_STATUS; bus.ren = 1'b1;
        #1;
        check("pre_rst_status", bus.rdata, 32'h1);
        check("pre_rst_tx", {31'd0, tx}, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'h1);
        check("async_rst_status", bus.rdata, 32'h0);
        check("async_rst_led", {24'd0, led}, 32'h0);
        bus.ren = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
